// File: rtl/semaforo_pkg.sv
// Light-code and fault-code definitions shared between the sequencer and the lamp driver.
package semaforo_pkg;

  // Vehicle light codes (3 bits)
  localparam logic [2:0] VF      = 3'b000;  // green ball + green arrow
  localparam logic [2:0] VFb     = 3'b001;  // green ball + blinking arrow
  localparam logic [2:0] VbFb    = 3'b010;  // blinking ball + blinking arrow
  localparam logic [2:0] V       = 3'b011;  // green ball
  localparam logic [2:0] Vb      = 3'b100;  // blinking ball
  localparam logic [2:0] AMA     = 3'b101;  // amber
  localparam logic [2:0] ROJ     = 3'b110;  // red
  localparam logic [2:0] VEH_INV = 3'b111;  // never legal

  // Pedestrian codes (2 bits)
  localparam logic [1:0] VER_P   = 2'b00;
  localparam logic [1:0] VER_Pb  = 2'b01;
  localparam logic [1:0] ROJ_P   = 2'b10;
  localparam logic [1:0] PED_INV = 2'b11;

  // Fault codes
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_CONFLICT = 2'b01;
  localparam logic [1:0] FC_INVALID  = 2'b10;
  localparam logic [1:0] FC_WDOG     = 2'b11;

  // Four vehicle codes plus the pedestrian code
  localparam int unsigned WORD_W = 14;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_FAILSAFE = 1'b1
  } state_t;

  typedef struct packed {
    logic rojo;
    logic ama;
    logic verde;
    logic flecha;
  } head_lamps_t;

  // Lamp pattern of one vehicle head for a given code and blink phase
  function automatic head_lamps_t veh_decode(input logic [2:0] code, input logic b);
    head_lamps_t l;
    l = '0;
    case (code)
      VF:      begin l.verde = 1'b1; l.flecha = 1'b1; end
      VFb:     begin l.verde = 1'b1; l.flecha = b;    end
      VbFb:    begin l.verde = b;    l.flecha = b;    end
      V:       l.verde = 1'b1;
      Vb:      l.verde = b;
      AMA:     l.ama   = 1'b1;
      ROJ:     l.rojo  = 1'b1;
      default: l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/semaforo_driver_blink_gen.sv
// Free-running blink phase: toggles every BLINK_HALF clocks, phase starts high out of reset.
module blink_gen #(
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  output logic phase
);

  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] cnt;

  // Prescaler counts 0..BLINK_HALF-1 and flips the phase on wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/semaforo_driver.sv
// Intersection lamp driver with independent safety monitor and latched flashing-amber fail-safe.
module semaforo_driver
  import semaforo_pkg::*;
#(
  parameter int unsigned BLINK_HALF   = 4,
  parameter int unsigned FAULT_FILTER = 2,
  parameter int unsigned WDOG_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] semaforo0,
  input  logic [2:0] semaforo1,
  input  logic [2:0] semaforo2,
  input  logic [2:0] semaforo3,
  input  logic [1:0] peatonal,
  output logic [3:0] lamp_rojo,
  output logic [3:0] lamp_ama,
  output logic [3:0] lamp_verde,
  output logic [3:0] lamp_flecha,
  output logic       ped_rojo,
  output logic       ped_verde,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned FILT_W = $clog2(FAULT_FILTER + 1);
  localparam int unsigned WD_W   = $clog2(WDOG_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FAULT_FILTER);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(WDOG_CYCLES);

  state_t            state;
  logic              blink;
  logic [FILT_W-1:0] filt_q;
  logic [WD_W-1:0]   wd_q;
  logic [WORD_W-1:0] prev_q;

  logic [3:0][2:0]   codes_c;
  logic [WORD_W-1:0] word_c;
  head_lamps_t       hl_c;
  logic [3:0]        rojo_c, ama_c, verde_c, flecha_c, non_red_c;
  logic              ped_rojo_c, ped_verde_c;
  logic              conflict_c, invalid_c, viol_c;
  logic [FILT_W-1:0] filt_next_c;
  logic [WD_W-1:0]   wd_next_c;
  logic              filt_hit_c, wd_hit_c, latch_c;
  logic [1:0]        code_c;

  assign codes_c = {semaforo3, semaforo2, semaforo1, semaforo0};
  assign word_c  = {semaforo3, semaforo2, semaforo1, semaforo0, peatonal};

  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk   (clk),
    .rst   (rst),
    .phase (blink)
  );

  // Lamp decode and conflict/invalid detection for the current input word
  always_comb begin
    hl_c      = '0;
    rojo_c    = '0;
    ama_c     = '0;
    verde_c   = '0;
    flecha_c  = '0;
    non_red_c = '0;
    invalid_c = (peatonal == PED_INV);
    for (int i = 0; i < 4; i++) begin
      hl_c         = veh_decode(codes_c[i], blink);
      rojo_c[i]    = hl_c.rojo;
      ama_c[i]     = hl_c.ama;
      verde_c[i]   = hl_c.verde;
      flecha_c[i]  = hl_c.flecha;
      non_red_c[i] = (codes_c[i] != ROJ);
      if (codes_c[i] == VEH_INV) invalid_c = 1'b1;
    end
    ped_rojo_c  = (peatonal == ROJ_P);
    ped_verde_c = (peatonal == VER_P) | ((peatonal == VER_Pb) & blink);
    conflict_c  = ((|non_red_c[1:0]) & (|non_red_c[3:2])) |
                  (((peatonal == VER_P) | (peatonal == VER_Pb)) & (|non_red_c));
  end

  // Persistence filter, watchdog and fault-cause arbitration
  always_comb begin
    viol_c      = conflict_c | invalid_c;
    filt_next_c = '0;
    if (viol_c) filt_next_c = (filt_q == FILT_MAX) ? filt_q : filt_q + FILT_W'(1);
    filt_hit_c  = viol_c & (filt_next_c == FILT_MAX);
    wd_next_c   = '0;
    if (word_c == prev_q) wd_next_c = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
    wd_hit_c    = (wd_next_c == WD_MAX);
    latch_c     = filt_hit_c | wd_hit_c;
    if (filt_hit_c) code_c = invalid_c ? FC_INVALID : FC_CONFLICT;
    else            code_c = FC_WDOG;
  end

  // RUN/FAILSAFE state machine with registered lamp and fault outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      filt_q      <= '0;
      wd_q        <= '0;
      prev_q      <= word_c;
      lamp_rojo   <= 4'b1111;
      lamp_ama    <= '0;
      lamp_verde  <= '0;
      lamp_flecha <= '0;
      ped_rojo    <= 1'b1;
      ped_verde   <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
    end else begin
      case (state)
        ST_RUN: begin
          filt_q <= filt_next_c;
          wd_q   <= wd_next_c;
          prev_q <= word_c;
          if (latch_c) begin
            state       <= ST_FAILSAFE;
            fault       <= 1'b1;
            fault_code  <= code_c;
            lamp_rojo   <= '0;
            lamp_ama    <= {4{blink}};
            lamp_verde  <= '0;
            lamp_flecha <= '0;
            ped_rojo    <= 1'b0;
            ped_verde   <= 1'b0;
          end else begin
            lamp_rojo   <= rojo_c;
            lamp_ama    <= ama_c;
            lamp_verde  <= verde_c;
            lamp_flecha <= flecha_c;
            ped_rojo    <= ped_rojo_c;
            ped_verde   <= ped_verde_c;
          end
        end
        default: begin
          lamp_rojo   <= '0;
          lamp_ama    <= {4{blink}};
          lamp_verde  <= '0;
          lamp_flecha <= '0;
          ped_rojo    <= 1'b0;
          ped_verde   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_semaforo_driver.sv
// Directed self-checking bench for semaforo_driver (default parameters 4/2/64).
module tb_semaforo_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] s0, s1, s2, s3;
  logic [1:0] ped;
  logic [3:0] lamp_rojo, lamp_ama, lamp_verde, lamp_flecha;
  logic       ped_rojo, ped_verde, fault;
  logic [1:0] fault_code;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;   // edges since reset release

  localparam logic [2:0] R = 3'b110;
  localparam logic [1:0] PR = 2'b10;

  semaforo_driver dut (
    .clk         (clk),
    .rst         (rst),
    .semaforo0   (s0),
    .semaforo1   (s1),
    .semaforo2   (s2),
    .semaforo3   (s3),
    .peatonal    (ped),
    .lamp_rojo   (lamp_rojo),
    .lamp_ama    (lamp_ama),
    .lamp_verde  (lamp_verde),
    .lamp_flecha (lamp_flecha),
    .ped_rojo    (ped_rojo),
    .ped_verde   (ped_verde),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  // Blink phase held in the phase flop after k edges since reset release
  function automatic logic bexp(input int k);
    return ((k / 4) % 2) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic set_word(input logic [2:0] a, b, c, d, input logic [1:0] p);
    s0 = a; s1 = b; s2 = c; s3 = d; ped = p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_word(R, R, R, R, PR);
    tick();
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    logic exp_pr;
    do_reset();
    n_checks += 6;
    if (lamp_rojo !== 4'b1111) begin n_fail++; $display("FAIL reset_rojo got=%b exp=1111", lamp_rojo); end
    if ({lamp_ama, lamp_verde, lamp_flecha} !== 12'h000) begin n_fail++; $display("FAIL reset_other got=%h exp=000", {lamp_ama, lamp_verde, lamp_flecha}); end
    if (ped_rojo !== 1'b1) begin n_fail++; $display("FAIL reset_ped_rojo got=%b exp=1", ped_rojo); end
    if (ped_verde !== 1'b0) begin n_fail++; $display("FAIL reset_ped_verde got=%b exp=0", ped_verde); end
    if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", fault); end
    if (fault_code !== 2'b00) begin n_fail++; $display("FAIL reset_code got=%b exp=00", fault_code); end
    for (int c = 0; c < 60; c++) begin
      exp_pr = ((c / 20) % 2) == 0;
      if (c % 20 == 0) set_word(R, R, R, R, exp_pr ? 2'b10 : 2'b00);
      tick();
      n_checks += 3;
      if (lamp_rojo !== 4'b1111) begin n_fail++; $display("FAIL idle_rojo c=%0d got=%b exp=1111", c, lamp_rojo); end
      if (fault !== 1'b0) begin n_fail++; $display("FAIL idle_fault c=%0d got=%b exp=0", c, fault); end
      if ({ped_rojo, ped_verde} !== {exp_pr, ~exp_pr}) begin n_fail++; $display("FAIL idle_ped c=%0d got=%b exp=%b", c, {ped_rojo, ped_verde}, {exp_pr, ~exp_pr}); end
    end
  endtask

  task automatic test_blink_arrow();
    do_reset();
    set_word(3'b001, R, R, R, PR);
    for (int c = 0; c < 16; c++) begin
      tick();
      n_checks += 4;
      if (lamp_verde !== 4'b0001) begin n_fail++; $display("FAIL arrow_verde c=%0d got=%b exp=0001", c, lamp_verde); end
      if (lamp_rojo !== 4'b1110) begin n_fail++; $display("FAIL arrow_rojo c=%0d got=%b exp=1110", c, lamp_rojo); end
      if (lamp_flecha !== {3'b000, bexp(n - 1)}) begin n_fail++; $display("FAIL arrow_flecha c=%0d got=%b exp=%b", c, lamp_flecha, {3'b000, bexp(n - 1)}); end
      if (fault !== 1'b0) begin n_fail++; $display("FAIL arrow_fault c=%0d got=%b exp=0", c, fault); end
    end
  endtask

  task automatic test_conflict_filter();
    do_reset();
    set_word(3'b011, R, 3'b011, R, PR);
    tick();
    n_checks += 2;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL glitch_fault got=%b exp=0", fault); end
    if (lamp_verde !== 4'b0101) begin n_fail++; $display("FAIL glitch_verde got=%b exp=0101", lamp_verde); end
    set_word(R, R, R, R, PR);
    tick();
    n_checks += 1;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL glitch_clear got=%b exp=0", fault); end
    set_word(3'b011, R, 3'b011, R, PR);
    tick();
    tick();
    n_checks += 2;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL conflict_fault got=%b exp=1", fault); end
    if (fault_code !== 2'b01) begin n_fail++; $display("FAIL conflict_code got=%b exp=01", fault_code); end
    set_word(R, R, R, R, 2'b00);
    for (int c = 0; c < 12; c++) begin
      n_checks += 4;
      if (lamp_ama !== {4{bexp(n - 1)}}) begin n_fail++; $display("FAIL failsafe_ama c=%0d got=%b exp=%b", c, lamp_ama, {4{bexp(n - 1)}}); end
      if ({lamp_rojo, lamp_verde, lamp_flecha} !== 12'h000) begin n_fail++; $display("FAIL failsafe_other c=%0d got=%h exp=000", c, {lamp_rojo, lamp_verde, lamp_flecha}); end
      if ({ped_rojo, ped_verde} !== 2'b00) begin n_fail++; $display("FAIL failsafe_ped c=%0d got=%b exp=00", c, {ped_rojo, ped_verde}); end
      if ({fault, fault_code} !== 3'b101) begin n_fail++; $display("FAIL failsafe_hold c=%0d got=%b exp=101", c, {fault, fault_code}); end
      tick();
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_word(3'b011, R, 3'b011, 3'b111, PR);
    tick();
    n_checks += 1;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL prio_early got=%b exp=0", fault); end
    tick();
    n_checks += 2;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL prio_fault got=%b exp=1", fault); end
    if (fault_code !== 2'b10) begin n_fail++; $display("FAIL prio_code got=%b exp=10", fault_code); end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int c = 0; c < 63; c++) tick();
    n_checks += 1;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL wdog_early got=%b exp=0", fault); end
    tick();
    n_checks += 2;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL wdog_fault got=%b exp=1", fault); end
    if (fault_code !== 2'b11) begin n_fail++; $display("FAIL wdog_code got=%b exp=11", fault_code); end
  endtask

  task automatic test_watchdog_near_miss();
    do_reset();
    for (int c = 0; c < 62; c++) tick();
    set_word(R, R, R, R, 2'b00);
    for (int c = 0; c < 40; c++) begin
      tick();
      n_checks += 1;
      if (fault !== 1'b0) begin n_fail++; $display("FAIL wdog_miss c=%0d got=%b exp=0", c, fault); end
    end
  endtask

  task automatic test_reset_from_fault();
    do_reset();
    set_word(3'b011, R, 3'b011, R, PR);
    tick();
    tick();
    n_checks += 1;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL refault_enter got=%b exp=1", fault); end
    do_reset();
    n_checks += 4;
    if ({fault, fault_code} !== 3'b000) begin n_fail++; $display("FAIL refault_clear got=%b exp=000", {fault, fault_code}); end
    if (lamp_rojo !== 4'b1111) begin n_fail++; $display("FAIL refault_rojo got=%b exp=1111", lamp_rojo); end
    if ({lamp_ama, lamp_verde, lamp_flecha} !== 12'h000) begin n_fail++; $display("FAIL refault_other got=%h exp=000", {lamp_ama, lamp_verde, lamp_flecha}); end
    if ({ped_rojo, ped_verde} !== 2'b10) begin n_fail++; $display("FAIL refault_ped got=%b exp=10", {ped_rojo, ped_verde}); end
    set_word(3'b100, R, R, R, PR);
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks += 2;
      if (lamp_verde !== {3'b000, bexp(n - 1)}) begin n_fail++; $display("FAIL resume_vb c=%0d got=%b exp=%b", c, lamp_verde, {3'b000, bexp(n - 1)}); end
      if ({lamp_rojo, lamp_flecha} !== 8'b1110_0000) begin n_fail++; $display("FAIL resume_vb_rf c=%0d got=%b exp=11100000", c, {lamp_rojo, lamp_flecha}); end
    end
    set_word(3'b010, R, R, R, PR);
    tick();
    n_checks += 1;
    if ({lamp_verde, lamp_flecha} !== {3'b000, bexp(n - 1), 3'b000, bexp(n - 1)}) begin n_fail++; $display("FAIL resume_vbfb got=%b exp=%b", {lamp_verde, lamp_flecha}, {3'b000, bexp(n - 1), 3'b000, bexp(n - 1)}); end
    set_word(R, 3'b101, R, R, PR);
    tick();
    n_checks += 2;
    if (lamp_ama !== 4'b0010) begin n_fail++; $display("FAIL resume_ama got=%b exp=0010", lamp_ama); end
    if (lamp_rojo !== 4'b1101) begin n_fail++; $display("FAIL resume_ama_rojo got=%b exp=1101", lamp_rojo); end
    set_word(R, R, R, R, 2'b01);
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks += 2;
      if ({ped_rojo, ped_verde} !== {1'b0, bexp(n - 1)}) begin n_fail++; $display("FAIL resume_pedb c=%0d got=%b exp=%b", c, {ped_rojo, ped_verde}, {1'b0, bexp(n - 1)}); end
      if (fault !== 1'b0) begin n_fail++; $display("FAIL resume_fault c=%0d got=%b exp=0", c, fault); end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_word(R, R, R, R, PR);
    test_reset();
    test_blink_arrow();
    test_conflict_filter();
    test_priority();
    test_watchdog();
    test_watchdog_near_miss();
    test_reset_from_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/semaforo_driver.md
# semaforo_driver

Receiving end of the intersection light-code bus. Consumes the four 3-bit vehicle light codes and the 2-bit pedestrian code from the sequencer and drives individual lamp outputs, generating the blink cadence locally. Also acts as an independent safety monitor: conflicting greens, illegal codes or a frozen sequencer latch a fail-safe flashing-amber mode that only reset clears.

## Interface
- BLINK_HALF, 4 — clock cycles per blink half-period; must be ≥ 1.
- FAULT_FILTER, 2 — consecutive cycles a conflict or invalid code must persist before a fault latches; must be ≥ 1.
- WDOG_CYCLES, 64 — cycles the input word may stay unchanged before the watchdog faults; must be > the longest sequencer state.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- semaforo0..semaforo3  in  3 each  vehicle light codes.
- peatonal  in  2  pedestrian code.
- lamp_rojo  out  4  red lamp, bit i = head i.
- lamp_ama  out  4  amber lamp.
- lamp_verde  out  4  green ball lamp.
- lamp_flecha  out  4  green arrow lamp.
- ped_rojo, ped_verde  out  1 each  pedestrian lamps.
- fault  out  1  latched fail-safe indicator.
- fault_code  out  2  00 none, 01 conflict, 10 invalid code, 11 watchdog.

## Operation
- Vehicle decode (g = ball, a = arrow; B = blink phase): 000 g=1 a=1; 001 g=1 a=B; 010 g=B a=B; 011 g=1; 100 g=B; 101 amber; 110 red; 111 invalid.
- Pedestrian decode: 00 verde=1; 01 verde=B; 10 rojo=1; 11 invalid.
- Blink generator: counter 0..BLINK_HALF-1; on wrap, B toggles. Free-running, also in fault mode.
- Conflict: any of heads {0,1} non-red while any of {2,3} non-red; or pedestrian code 00/01 while any head non-red.
- Invalid: any vehicle code 111 or pedestrian code 11.
- Filter counter: counts consecutive violating cycles, clears on any clean cycle. Fault latches on the edge where the count reaches FAULT_FILTER.
- Watchdog: previous 14-bit input word registered. Count clears when the word changes, otherwise increments, saturating at WDOG_CYCLES. Fault latches when the count reaches WDOG_CYCLES.
- Simultaneous causes resolve to a single code, priority invalid > conflict > watchdog. fault_code is frozen once latched.
- Fault mode:
  - lamp_ama = {4{B}}; all other vehicle lamps 0.
  - ped_rojo = ped_verde = 0.
  - Inputs are ignored until rst.
- States: RUN (decode to lamps) and FAILSAFE. RUN→FAILSAFE on a latched fault. Only rst leaves FAILSAFE.

## Timing
- Reset values:
  - lamp_rojo = 4'b1111; all other vehicle lamps 0.
  - ped_rojo = 1, ped_verde = 0.
  - fault = 0, fault_code = 00.
  - B = 1, blink counter = 0, filter and watchdog counters = 0.
  - Previous-word register loads the current inputs.
- All outputs are registered; input-to-lamp latency is 1 cycle.
- Fault entry: fault, fault_code and the fail-safe lamp pattern all appear in the cycle after the latching edge.
- The fault path has no 1-cycle-late normal output; lamps switch on the same edge as fault.
- rst asserted mid-fault: fault cleared on that edge, outputs return to reset values, monitoring resumes the next cycle.
- B toggles every BLINK_HALF cycles; the first toggle is BLINK_HALF cycles after reset release.

## Structure
- Shared package `semaforo_pkg`:
  - light-code constants VF, VFb, VbFb, V, Vb, AMA, ROJ, VER_P, VER_Pb, ROJ_P;
  - fault-code constants;
  - all values shared with the sequencer.
- One sub-module, `blink_gen` (prescaler plus phase flop, parameter BLINK_HALF). Decode, monitor and output registers stay in the top module.

## Test plan
- Reset, then inputs {110,110,110,110,10} → lamp_rojo=1111, ped_rojo=1, fault=0, held for 60 cycles with inputs toggled between two legal words every 20 cycles.
- semaforo0=001, others 110 → lamp_verde[0]=1; lamp_flecha[0] toggles every 4 cycles; lamp_rojo=1110.
- semaforo0=011 and semaforo2=011 for exactly 1 cycle → no fault. Same for 2 cycles → fault=1, fault_code=01; lamp_ama blinks 1111/0000 every 4 cycles; ped lamps 0.
- semaforo3=111 together with a conflict for 2 cycles → fault_code=10 (priority check).
- Legal word held constant for 64 cycles → fault_code=11 one cycle after the 64th unchanged cycle. Changing the word at cycle 63 → no fault.
- rst pulsed while in FAILSAFE → next cycle fault=0, all-red outputs; legal sequence resumes normal decode.
